cmp_iter: RTL and testbench
===========================

# cmp_iter

Parametrised, multi-cycle comparison unit for the ALU. It generalises the single-mode, 32-bit combinational not-equal operator to a `WIDTH`-bit operand scanned `SLICE` bits per cycle, MSB slice first. It supports six comparison modes and signed/unsigned operation, with early termination on the first differing slice. It sits beside the ALU operators, behind a start/busy/done handshake, and returns the same S/Z/V/N result format.

## Interface

Parameters:

- `WIDTH`, 32: operand and result width. Must be a multiple of `SLICE`.
- `SLICE`, 8: bits compared per cycle, 1..`WIDTH`. `NSLICE` = `WIDTH`/`SLICE`.

Ports:

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `A`  in  `WIDTH`  operand A, latched on accepted start.
- `B`  in  `WIDTH`  operand B, latched on accepted start.
- `Sign`  in  1  1 = two's-complement compare, 0 = unsigned; latched.
- `Mode`  in  3  0 EQ, 1 NEQ, 2 LT, 3 LE, 4 GT, 5 GE, 6/7 reserved; latched.
- `busy`  out  1  high while in SCAN.
- `done`  out  1  one-cycle pulse when S/Z become valid.
- `S`  out  `WIDTH`  result, 0 or 1, zero-extended.
- `Z`  out  1  1 iff S == 0.
- `V`  out  1  constant 0.
- `N`  out  1  constant 0.

## Operation

- States: IDLE and SCAN.
- **IDLE, start=1:**
  - Latch A, B, Sign and Mode.
  - Set slice index to `NSLICE`-1.
  - Clear `eq_acc` to 1.
  - Go to SCAN.
- **SCAN:** each cycle compares slice[idx] of the latched A and B.
  - For idx = `NSLICE`-1 with Sign=1, invert the MSB of both slices before the unsigned compare. This maps signed order to unsigned order.
  - Slices differ: `eq` = 0, `lt` = (a_slice < b_slice). Terminate.
  - Slices equal and idx = 0: `eq` = 1, `lt` = 0. Terminate.
  - Otherwise: idx decrements and SCAN continues.
- **Result on terminate:**
  - EQ: `eq`
  - NEQ: !`eq`
  - LT: `lt`
  - LE: `lt` | `eq`
  - GT: !`lt` & !`eq`
  - GE: !`lt`
  - Reserved modes: 0.
- **Terminate cycle:**
  - Register S = {0…, result} and Z = !result.
  - Assert `done` for the following cycle.
  - Return to IDLE.
- S and Z hold their value until the next `done`.
- `start` while busy is ignored. Latched operands are not disturbed.
- `start` in the cycle `done` is high is accepted, since the unit is already in IDLE.
- `SLICE` = `WIDTH`: every operation takes exactly one SCAN cycle.

## Timing

- Reset values:
  - state IDLE, `busy` = 0, `done` = 0
  - S = 0, Z = 1, V = 0, N = 0
  - internal idx = 0, `eq_acc` = 1
- `reset` has priority over everything. Asserted mid-SCAN, the next cycle shows the reset values and the operation is discarded.
- Latency: start sampled at edge t.
  - `busy` is high after edge t.
  - k SCAN cycles follow, where k = `NSLICE` − (index of first differing slice); k = `NSLICE` if equal.
  - `done`, S and Z update at edge t+k. `done` is high for exactly one cycle; `busy` is low in that same cycle.
- Throughput: one operation per k+1 cycles when back-to-back starts are issued in the `done` cycle. Minimum 2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

WIDTH=32, SLICE=8 throughout.

1. NEQ, A=B=0x12345678 -> `busy` for 4 cycles; `done` at t+4; S=0, Z=1.
2. NEQ, A=0x80000000, B=0x00000000, Sign=0 -> `done` at t+1, S=1, Z=0. Same with EQ -> S=0, Z=1.
3. LT, A=0xFFFFFFFF, B=0x00000001:
   - Sign=1 -> S=1 (−1 < 1), `done` at t+1.
   - Sign=0 -> S=0.
   - GT, Sign=0 -> S=1.
4. LE and GE with A=B=0x0000007F -> S=1 for both, `done` at t+4. GT -> S=0. Mode=6 -> S=0, Z=1.
5. NEQ A=B=0; pulse `start` with A=1 at t+2 -> ignored, `done` at t+4 with S=0. Next run: assert `reset` at t+2 -> `busy`=0, `done`=0, S=0, Z=1 at t+3, and no `done` pulse follows.
6. Issue EQ (A=B=5) then LT (Sign=1, A=0x80000000, B=0) with the second start in the first op's `done` cycle -> first `done` S=1. Second accepted immediately; `done` one cycle later with S=1.

Source files
------------

// File: rtl/cmp_iter.sv
// Multi-cycle slice-serial comparator returning S/Z/V/N results.
// Operands are scanned MSB slice first and the scan stops at the first differing slice.
module cmp_iter #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sign,
    input  logic [2:0]       Mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Z,
    output logic             V,
    output logic             N
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NSLICE - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sign_r;
    logic [2:0]       mode_r;
    logic [IW-1:0]    idx_r;
    logic             eq_acc_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] s_r;
    logic             z_r;

    logic             load_s;
    logic             term_s;
    logic [SLICE-1:0] a_sl_s;
    logic [SLICE-1:0] b_sl_s;
    logic             flip_s;
    logic             diff_s;
    logic             eq_s;
    logic             lt_s;
    logic             result_s;

    function automatic logic mode_result(input logic [2:0] mode,
                                         input logic       eq,
                                         input logic       lt);
        logic r;
        case (mode)
            3'd0:    r = eq;
            3'd1:    r = ~eq;
            3'd2:    r = lt;
            3'd3:    r = lt | eq;
            3'd4:    r = ~lt & ~eq;
            3'd5:    r = ~lt;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Current-slice comparison; the top slice gets its MSB flipped in signed mode
    // so that two's-complement order becomes plain unsigned order.
    always_comb begin
        a_sl_s = a_r[int'(idx_r) * SLICE +: SLICE];
        b_sl_s = b_r[int'(idx_r) * SLICE +: SLICE];
        flip_s = sign_r & (idx_r == IDX_TOP);
        a_sl_s[SLICE-1] = a_sl_s[SLICE-1] ^ flip_s;
        b_sl_s[SLICE-1] = b_sl_s[SLICE-1] ^ flip_s;
        diff_s   = (a_sl_s != b_sl_s);
        eq_s     = eq_acc_r & ~diff_s;
        lt_s     = diff_s & (a_sl_s < b_sl_s);
        result_s = mode_result(mode_r, eq_s, lt_s);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        term_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s      = 1'b1;
                    state_nxt_s = SCAN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                if (diff_s || (idx_r == {IW{1'b0}})) begin
                    term_s      = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SCAN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand latch, slice walk and registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            sign_r   <= 1'b0;
            mode_r   <= 3'd0;
            idx_r    <= {IW{1'b0}};
            eq_acc_r <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            s_r      <= {WIDTH{1'b0}};
            z_r      <= 1'b1;
        end else begin
            busy_r <= (state_nxt_s == SCAN);
            done_r <= term_s;
            if (load_s) begin
                a_r      <= A;
                b_r      <= B;
                sign_r   <= Sign;
                mode_r   <= Mode;
                idx_r    <= IDX_TOP;
                eq_acc_r <= 1'b1;
            end else if (term_s) begin
                s_r <= WIDTH'(result_s);
                z_r <= ~result_s;
            end else if (state_r == SCAN) begin
                idx_r    <= idx_r - {{(IW-1){1'b0}}, 1'b1};
                eq_acc_r <= eq_s;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign S    = s_r;
    assign Z    = z_r;
    assign V    = 1'b0;
    assign N    = 1'b0;

endmodule

// File: tb/tb_cmp_iter.sv
// Self-checking bench for cmp_iter (WIDTH=32, SLICE=8): directed scenarios plus
// randomized operations checked against an arithmetic reference model.
module tb_cmp_iter;

    localparam int W  = 32;
    localparam int SL = 8;
    localparam int NS = W / SL;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sign;
    logic [2:0]    mode;
    logic          busy;
    logic          done;
    logic [W-1:0]  s;
    logic          z;
    logic          v;
    logic          n;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    cmp_iter #(.WIDTH(W), .SLICE(SL)) dut (
        .clk(clk), .reset(reset), .start(start), .A(a), .B(b),
        .Sign(sign), .Mode(mode), .busy(busy), .done(done),
        .S(s), .Z(z), .V(v), .N(n)
    );

    always #5 clk = ~clk;

    // Reference: plain signed/unsigned arithmetic comparison.
    function automatic logic exp_res(input logic [31:0] x, input logic [31:0] y,
                                     input logic sg, input logic [2:0] md);
        logic eq;
        logic lt;
        eq = (x == y);
        lt = sg ? ($signed(x) < $signed(y)) : (x < y);
        case (md)
            3'd0:    return eq;
            3'd1:    return !eq;
            3'd2:    return lt;
            3'd3:    return lt || eq;
            3'd4:    return !lt && !eq;
            3'd5:    return !lt;
            default: return 1'b0;
        endcase
    endfunction

    // Reference latency: slices scanned down to the highest differing bit.
    function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] d;
        int k;
        d = x ^ y;
        k = NS;
        for (int i = 0; i < 32; i++) if (d[i]) k = NS - i / SL;
        return k;
    endfunction

    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic isg,
                         input logic [2:0] imd, input bit at_neg,
                         output int lat, output int busy_n, output bit busy0);
        if (at_neg) @(negedge clk);
        a = ia; b = ib; sign = isg; mode = imd; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        busy0  = busy;
        busy_n = busy ? 1 : 0;
        lat    = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = '0; b = '0; sign = 1'b0; mode = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        chk_cnt++; if (s !== 32'd0) $display("FAIL reset_s got %h want 0", s); else pass_cnt++;
        chk_cnt++; if (z !== 1'b1) $display("FAIL reset_z got %b want 1", z); else pass_cnt++;
        chk_cnt++; if (v !== 1'b0 || n !== 1'b0) $display("FAIL reset_vn got %b%b want 00", v, n); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_neq_equal();
        int lat; int bn; bit b0;
        do_op(32'h12345678, 32'h12345678, 1'b0, 3'd1, 1'b1, lat, bn, b0);
        chk_cnt++; if (lat !== 4) $display("FAIL neq_eq_lat got %0d want 4", lat); else pass_cnt++;
        chk_cnt++; if (bn !== 4) $display("FAIL neq_eq_busy got %0d want 4", bn); else pass_cnt++;
        chk_cnt++; if (s !== 32'd0 || z !== 1'b1) $display("FAIL neq_eq_sz got %h/%b want 0/1", s, z); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL neq_eq_busy_done got %b want 0", busy); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if (done !== 1'b0) $display("FAIL done_pulse got %b want 0", done); else pass_cnt++;
        chk_cnt++; if (s !== 32'd0 || z !== 1'b1) $display("FAIL sz_hold got %h/%b want 0/1", s, z); else pass_cnt++;
    endtask

    task automatic test_msb_diff();
        int lat; int bn; bit b0;
        do_op(32'h80000000, 32'h0, 1'b0, 3'd1, 1'b1, lat, bn, b0);
        chk_cnt++; if (lat !== 1) $display("FAIL msb_neq_lat got %0d want 1", lat); else pass_cnt++;
        chk_cnt++; if (s !== 32'd1 || z !== 1'b0) $display("FAIL msb_neq_sz got %h/%b want 1/0", s, z); else pass_cnt++;
        do_op(32'h80000000, 32'h0, 1'b0, 3'd0, 1'b1, lat, bn, b0);
        chk_cnt++; if (lat !== 1) $display("FAIL msb_eq_lat got %0d want 1", lat); else pass_cnt++;
        chk_cnt++; if (s !== 32'd0 || z !== 1'b1) $display("FAIL msb_eq_sz got %h/%b want 0/1", s, z); else pass_cnt++;
    endtask

    task automatic test_lt_signed();
        int lat; int bn; bit b0;
        do_op(32'hFFFFFFFF, 32'h1, 1'b1, 3'd2, 1'b1, lat, bn, b0);
        chk_cnt++; if (lat !== 1) $display("FAIL slt_lat got %0d want 1", lat); else pass_cnt++;
        chk_cnt++; if (s !== 32'd1) $display("FAIL slt_s got %h want 1", s); else pass_cnt++;
        do_op(32'hFFFFFFFF, 32'h1, 1'b0, 3'd2, 1'b1, lat, bn, b0);
        chk_cnt++; if (s !== 32'd0 || z !== 1'b1) $display("FAIL ult_sz got %h/%b want 0/1", s, z); else pass_cnt++;
        do_op(32'hFFFFFFFF, 32'h1, 1'b0, 3'd4, 1'b1, lat, bn, b0);
        chk_cnt++; if (s !== 32'd1) $display("FAIL ugt_s got %h want 1", s); else pass_cnt++;
    endtask

    task automatic test_le_ge();
        int lat; int bn; bit b0;
        do_op(32'h7F, 32'h7F, 1'b0, 3'd3, 1'b1, lat, bn, b0);
        chk_cnt++; if (s !== 32'd1 || lat !== 4) $display("FAIL le_eq got s=%h lat=%0d want 1/4", s, lat); else pass_cnt++;
        do_op(32'h7F, 32'h7F, 1'b0, 3'd5, 1'b1, lat, bn, b0);
        chk_cnt++; if (s !== 32'd1 || lat !== 4) $display("FAIL ge_eq got s=%h lat=%0d want 1/4", s, lat); else pass_cnt++;
        do_op(32'h7F, 32'h7F, 1'b0, 3'd4, 1'b1, lat, bn, b0);
        chk_cnt++; if (s !== 32'd0) $display("FAIL gt_eq got %h want 0", s); else pass_cnt++;
        do_op(32'h7F, 32'h7F, 1'b0, 3'd6, 1'b1, lat, bn, b0);
        chk_cnt++; if (s !== 32'd0 || z !== 1'b1) $display("FAIL reserved got %h/%b want 0/1", s, z); else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        a = 32'h0; b = 32'h0; sign = 1'b0; mode = 3'd1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        a = 32'h1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; a = 32'h0;
        lat = 0;
        for (int i = 3; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        chk_cnt++; if (lat !== 4) $display("FAIL ign_lat got %0d want 4", lat); else pass_cnt++;
        chk_cnt++; if (s !== 32'd0 || z !== 1'b1) $display("FAIL ign_sz got %h/%b want 0/1", s, z); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL ign_restart got busy=%b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat; int bn; bit b0; int dcnt;
        do_op(32'h1, 32'h0, 1'b0, 3'd1, 1'b1, lat, bn, b0);
        chk_cnt++; if (s !== 32'd1) $display("FAIL pre_rst_s got %h want 1", s); else pass_cnt++;
        @(negedge clk);
        a = 32'h0; b = 32'h0; sign = 1'b0; mode = 3'd1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy got %b want 1", busy); else pass_cnt++;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid_bd got %b%b want 00", busy, done); else pass_cnt++;
        chk_cnt++; if (s !== 32'd0 || z !== 1'b1) $display("FAIL rst_mid_sz got %h/%b want 0/1", s, z); else pass_cnt++;
        @(negedge clk); reset = 1'b0;
        dcnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk_cnt++; if (dcnt !== 0) $display("FAIL rst_mid_nodone got %0d want 0", dcnt); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat; int bn; bit b0;
        do_op(32'h5, 32'h5, 1'b0, 3'd0, 1'b1, lat, bn, b0);
        chk_cnt++; if (s !== 32'd1 || lat !== 4) $display("FAIL b2b_first got s=%h lat=%0d want 1/4", s, lat); else pass_cnt++;
        do_op(32'h80000000, 32'h0, 1'b1, 3'd2, 1'b0, lat, bn, b0);
        chk_cnt++; if (b0 !== 1'b1) $display("FAIL b2b_accept got busy=%b want 1", b0); else pass_cnt++;
        chk_cnt++; if (s !== 32'd1 || lat !== 1) $display("FAIL b2b_second got s=%h lat=%0d want 1/1", s, lat); else pass_cnt++;
    endtask

    task automatic test_random();
        int lat; int bn; bit b0;
        logic [31:0] ra, rb;
        logic rs;
        logic [2:0] rm;
        logic er;
        int el;
        for (int it = 0; it < 80; it++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            rm = 3'($urandom_range(0, 7));
            er = exp_res(ra, rb, rs, rm);
            el = exp_lat(ra, rb);
            do_op(ra, rb, rs, rm, bit'($urandom_range(0, 1)), lat, bn, b0);
            chk_cnt++;
            if (s !== {31'd0, er} || z !== !er || lat !== el || v !== 1'b0 || n !== 1'b0)
                $display("FAIL rand_%0d a=%h b=%h sg=%b md=%0d got s=%h z=%b lat=%0d want s=%0d z=%b lat=%0d",
                         it, ra, rb, rs, rm, s, z, lat, er, !er, el);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_neq_equal();
        test_msb_diff();
        test_lt_signed();
        test_le_ge();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
